// File: rtl/multi_zone_dripper_if.sv
// multi_zone_dripper_if: groups the zone sensor inputs, supply status and valve outputs of the dripper block.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is a level that is sampled each cycle.
interface multi_zone_dripper_if #(
  parameter int ZONES = 4
);
  localparam int OCW = $clog2(ZONES + 1);

  logic [ZONES-1:0] air_humidity;
  logic [ZONES-1:0] low_temperature;
  logic             mid_water_level;
  logic             critical_level;
  logic             sensor_error;
  logic [ZONES-1:0] dripper_valvule;
  logic [OCW-1:0]   open_count;
  logic             inhibited;
  logic [ZONES-1:0] timeout;

  // Controller side: drives the sensors, watches the valves.
  modport master (
    output air_humidity, low_temperature, mid_water_level, critical_level, sensor_error,
    input  dripper_valvule, open_count, inhibited, timeout
  );

  // Dripper side: reads the sensors, drives the valves.
  modport slave (
    input  air_humidity, low_temperature, mid_water_level, critical_level, sensor_error,
    output dripper_valvule, open_count, inhibited, timeout
  );
endinterface

// File: rtl/multi_zone_dripper.sv
// multi_zone_dripper: per-zone drip demand, anti-chatter valve FSMs (ON_MIN/OFF_MIN), MAX_OPEN cap, round-robin grants.
// Latency: a valve opens on the edge after its demand is seen; an inhibit closes every valve within one cycle.
// Backpressure: none; demand beyond the cap waits for a grant. Optional macro DRIPPER_MAXON_EN adds a sticky max-on timeout.
module multi_zone_dripper #(
  parameter int ZONES    = 4,
  parameter int ON_MIN   = 8,
  parameter int OFF_MIN  = 4,
  parameter int MAX_OPEN = 2,
  parameter int CNT_W    = 8,
  parameter int MAX_ON   = 64
) (
  input logic                 clock,
  input logic                 reset,
  multi_zone_dripper_if.slave bus
);
  localparam int PW  = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int OCW = $clog2(ZONES + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_MIN - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_MIN - 1);
  localparam logic [OCW-1:0]   CAP      = OCW'(MAX_OPEN);
`ifdef DRIPPER_MAXON_EN
  localparam logic [CNT_W-1:0] MAXON_LAST = CNT_W'(MAX_ON - 1);
`endif

  typedef enum logic [1:0] {
    HOLD_OFF = 2'd0,
    READY    = 2'd1,
    OPEN     = 2'd2
  } zone_state_t;

  zone_state_t      state_q [ZONES];
  zone_state_t      state_d [ZONES];
  logic [CNT_W-1:0] cnt_q   [ZONES];
  logic [CNT_W-1:0] cnt_d   [ZONES];
  logic [PW-1:0]    ptr_q;
  logic [ZONES-1:0] valve_q;
  logic [ZONES-1:0] valve_d;
  logic [OCW-1:0]   open_cnt_q;
  logic [OCW-1:0]   open_cnt_d;
  logic             inh;
  logic             inh_q;
  logic [ZONES-1:0] demand;
  logic             grant_vld;
  logic [PW-1:0]    grant_idx;
  logic [PW-1:0]    scan_idx;
  int               scan_sum;
`ifdef DRIPPER_MAXON_EN
  logic [ZONES-1:0] timeout_q;
  logic [ZONES-1:0] timeout_d;
`endif

  assign inh = bus.critical_level | bus.sensor_error;

  // Drip demand per zone: humid air and either cold climate or a supply below the middle level.
  always_comb begin
    demand = '0;
    for (int i = 0; i < ZONES; i++) begin
      demand[i] = bus.air_humidity[i] & (bus.low_temperature[i] | ~bus.mid_water_level);
    end
  end

  // Round-robin arbiter: first READY demanding zone from the pointer wins, if the registered count is under the cap.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    scan_sum  = 0;
    if (!inh && (open_cnt_q < CAP)) begin
      for (int k = 0; k < ZONES; k++) begin
        scan_sum = int'(ptr_q) + k;
        if (scan_sum >= ZONES) scan_sum = scan_sum - ZONES;
        scan_idx = PW'(scan_sum);
        if (!grant_vld && (state_q[scan_idx] == READY) && demand[scan_idx]) begin
          grant_vld = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  // Per-zone next state; an inhibit parks every zone in HOLD_OFF so all of them serve a full OFF_MIN afterwards.
  always_comb begin
    valve_d    = '0;
    open_cnt_d = '0;
`ifdef DRIPPER_MAXON_EN
    timeout_d  = timeout_q;
`endif
    for (int i = 0; i < ZONES; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (inh) begin
        state_d[i] = HOLD_OFF;
        cnt_d[i]   = OFF_LOAD;
      end else begin
        case (state_q[i])
          HOLD_OFF: begin
            if (cnt_q[i] == '0) state_d[i] = READY;
            else                cnt_d[i]   = cnt_q[i] - 1'b1;
          end
          READY: begin
            if (grant_vld && (grant_idx == PW'(i))) begin
              state_d[i] = OPEN;
              cnt_d[i]   = '0;
            end
          end
          OPEN: begin
`ifdef DRIPPER_MAXON_EN
            if (cnt_q[i] == MAXON_LAST) begin
              state_d[i]   = HOLD_OFF;
              cnt_d[i]     = OFF_LOAD;
              timeout_d[i] = 1'b1;
            end else
`endif
            if (!demand[i] && (cnt_q[i] >= ON_LAST)) begin
              state_d[i] = HOLD_OFF;
              cnt_d[i]   = OFF_LOAD;
            end else if (cnt_q[i] != {CNT_W{1'b1}}) begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
          default: begin
            state_d[i] = HOLD_OFF;
            cnt_d[i]   = OFF_LOAD;
          end
        endcase
      end
      valve_d[i] = (state_d[i] == OPEN);
      open_cnt_d = open_cnt_d + OCW'(valve_d[i]);
    end
  end

  // Zone FSMs, pointer and registered outputs; reset closes every valve without waiting for an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ZONES; i++) begin
        state_q[i] <= HOLD_OFF;
        cnt_q[i]   <= '0;
      end
      ptr_q      <= '0;
      valve_q    <= '0;
      open_cnt_q <= '0;
      inh_q      <= 1'b0;
`ifdef DRIPPER_MAXON_EN
      timeout_q  <= '0;
`endif
    end else begin
      for (int i = 0; i < ZONES; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      valve_q    <= valve_d;
      open_cnt_q <= open_cnt_d;
      inh_q      <= inh;
`ifdef DRIPPER_MAXON_EN
      timeout_q  <= timeout_d;
`endif
      if (grant_vld) begin
        ptr_q <= (grant_idx == PW'(ZONES - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  assign bus.dripper_valvule = valve_q;
  assign bus.open_count      = open_cnt_q;
  assign bus.inhibited       = inh_q;
`ifdef DRIPPER_MAXON_EN
  assign bus.timeout         = timeout_q;
`else
  assign bus.timeout         = '0;
`endif
endmodule

// File: tb/tb_multi_zone_dripper.sv
// tb_multi_zone_dripper: directed vectors for the multi-zone dripper with hand-computed valve timelines.
// Latency: inputs change 1 ns after a rising edge, outputs are sampled at that same point.
// Backpressure: none; each vector runs for a fixed number of cycles.
module tb_multi_zone_dripper;
  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  multi_zone_dripper_if #(.ZONES(4)) bus ();

  multi_zone_dripper #(
    .ZONES(4), .ON_MIN(8), .OFF_MIN(4), .MAX_OPEN(2), .CNT_W(8), .MAX_ON(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] air, input logic [3:0] temp, input logic mid,
                       input logic crit, input logic serr);
    bus.air_humidity    = air;
    bus.low_temperature = temp;
    bus.mid_water_level = mid;
    bus.critical_level  = crit;
    bus.sensor_error    = serr;
  endtask

  // Leaves the DUT one edge after release: every zone READY, pointer 0.
  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    tick();
    check("rst_valve", 32'(bus.dripper_valvule), 32'h0);
    check("rst_count", 32'(bus.open_count), 32'h0);
    check("rst_inh", 32'(bus.inhibited), 32'h0);
    check("rst_timeout", 32'(bus.timeout), 32'h0);

    // Single zone: open latency, ON_MIN hold after demand drops, OFF_MIN before reopening.
    apply_reset();
    drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    check("t1_pre", 32'(bus.dripper_valvule), 32'h0);
    tick();
    check("t1_open", 32'(bus.dripper_valvule), 32'h1);
    check("t1_count", 32'(bus.open_count), 32'h1);
    tick();
    drive(4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    for (int k = 7; k <= 13; k++) begin
      check("t1_onmin_hold", 32'(bus.dripper_valvule), 32'h1);
      tick();
    end
    check("t1_close", 32'(bus.dripper_valvule), 32'h0);
    check("t1_close_count", 32'(bus.open_count), 32'h0);
    tick();
    drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    for (int k = 15; k <= 18; k++) begin
      check("t1_offmin_hold", 32'(bus.dripper_valvule), 32'h0);
      tick();
    end
    check("t1_reopen", 32'(bus.dripper_valvule), 32'h1);

    // All zones demanding: cap of two, then round-robin hands the freed slot to zone 2.
    apply_reset();
    drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    tick();
    check("t2_first", 32'(bus.dripper_valvule), 32'h1);
    tick();
    check("t2_second", 32'(bus.dripper_valvule), 32'h3);
    tick();
    drive(4'b1110, 4'b0000, 1'b0, 1'b0, 1'b0);
    for (int k = 3; k <= 8; k++) begin
      check("t2_cap_valve", 32'(bus.dripper_valvule), 32'h3);
      check("t2_cap_count", 32'(bus.open_count), 32'h2);
      tick();
    end
    check("t2_z0_closed", 32'(bus.dripper_valvule), 32'h2);
    check("t2_z0_count", 32'(bus.open_count), 32'h1);
    tick();
    check("t2_rr_zone2", 32'(bus.dripper_valvule), 32'h6);
    check("t2_rr_count", 32'(bus.open_count), 32'h2);
    tick();
    check("t2_zone3_waits", 32'(bus.dripper_valvule), 32'h6);
`ifndef DRIPPER_MAXON_EN
    check("t2_timeout_tied", 32'(bus.timeout), 32'h0);
`endif

    // One-cycle critical pulse closes both open zones early and forces a full OFF_MIN.
    apply_reset();
    drive(4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0);
    tick();
    check("t3_open0", 32'(bus.dripper_valvule), 32'h1);
    tick();
    check("t3_open1", 32'(bus.dripper_valvule), 32'h3);
    tick();
    check("t3_pre_pulse", 32'(bus.dripper_valvule), 32'h3);
    drive(4'b0011, 4'b0011, 1'b1, 1'b1, 1'b0);
    tick();
    drive(4'b0011, 4'b0011, 1'b1, 1'b0, 1'b0);
    check("t3_inh_set", 32'(bus.inhibited), 32'h1);
    check("t3_count0", 32'(bus.open_count), 32'h0);
    for (int k = 4; k <= 8; k++) begin
      check("t3_closed", 32'(bus.dripper_valvule), 32'h0);
      tick();
      if (k == 4) check("t3_inh_clear", 32'(bus.inhibited), 32'h0);
    end
    check("t3_reopen0", 32'(bus.dripper_valvule), 32'h1);
    tick();
    check("t3_reopen1", 32'(bus.dripper_valvule), 32'h3);

    // Sensor fault held for ten cycles with every zone demanding.
    apply_reset();
    drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      check("t4_valve_blocked", 32'(bus.dripper_valvule), 32'h0);
      check("t4_count_blocked", 32'(bus.open_count), 32'h0);
      if (k >= 1) check("t4_inh_held", 32'(bus.inhibited), 32'h1);
      tick();
    end
    drive(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("t4_inh_tail", 32'(bus.inhibited), 32'h1);
    for (int k = 0; k < 5; k++) begin
      check("t4_offmin_valve", 32'(bus.dripper_valvule), 32'h0);
      tick();
      if (k == 0) check("t4_inh_clear", 32'(bus.inhibited), 32'h0);
    end
    check("t4_first_grant", 32'(bus.dripper_valvule), 32'h1);
    tick();
    check("t4_second_grant", 32'(bus.dripper_valvule), 32'h3);

    // Asynchronous reset mid-open, then reopening on the second edge after release.
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_valve", 32'(bus.dripper_valvule), 32'h0);
    check("t5_async_count", 32'(bus.open_count), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    check("t5_edge1", 32'(bus.dripper_valvule), 32'h0);
    tick();
    check("t5_edge2", 32'(bus.dripper_valvule), 32'h1);

`ifdef DRIPPER_MAXON_EN
    // Continuous demand on zone 0 hits the 16-cycle max-on limit.
    apply_reset();
    drive(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 1; k <= 16; k++) begin
      check("t6_open_run", 32'(bus.dripper_valvule), 32'h1);
      tick();
    end
    check("t6_forced_close", 32'(bus.dripper_valvule), 32'h0);
    check("t6_timeout", 32'(bus.timeout), 32'h1);
    for (int k = 18; k <= 21; k++) begin
      tick();
      check("t6_offmin", 32'(bus.dripper_valvule), 32'h0);
    end
    tick();
    check("t6_reopen", 32'(bus.dripper_valvule), 32'h1);
    check("t6_timeout_sticky", 32'(bus.timeout), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
